// File: rtl/axi_rd_mon_pkg.sv
// axi_rd_mon_pkg: shared types and constants for the AXI4 read-channel monitor.
package axi_rd_mon_pkg;

  // Widest ARID/RID the tracking table can hold; narrower IDs are zero-extended.
  localparam int ID_MAX_W = 16;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [7:0]          len;
    logic [7:0]          cnt;
  } rd_entry_t;

  // Sticky error flag bit positions
  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_RID_UNKNOWN = 1;
  localparam int ERR_RLAST_EARLY = 2;
  localparam int ERR_RLAST_MISS  = 3;
  localparam int ERR_RRESP       = 4;
  localparam int ERR_AR_UNSTABLE = 5;
  localparam int ERR_AR_ILLEGAL  = 6;
  localparam int ERR_W           = 7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_mon_table.sv
// axi_rd_mon_table: compacting age queue of outstanding read bursts.
// Entry 0 is the oldest; an R beat matches the oldest entry with its ID.
module axi_rd_mon_table #(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8,
  localparam int CNT_W  = $clog2(MAX_OUT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [ID_W-1:0]  i_push_id,
  input  logic [7:0]       i_push_len,
  input  logic             i_pop,
  input  logic [ID_W-1:0]  i_pop_id,
  input  logic             i_pop_last,
  output logic [CNT_W-1:0] o_count,
  output logic             o_retire,
  output logic             o_unknown,
  output logic             o_early,
  output logic             o_missing,
  output logic             o_overflow
);
  import axi_rd_mon_pkg::*;

  localparam int IDX_W = $clog2(MAX_OUT);

  rd_entry_t        r_tab   [MAX_OUT];
  rd_entry_t        w_nxt   [MAX_OUT];
  rd_entry_t        w_shift [MAX_OUT];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_ret;
  logic [CNT_W-1:0] w_count_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_tail;
  logic             w_hit;
  logic             w_at_end;
  logic             w_inc;
  logic             w_accept;

  // Each slot's shift-down source is the slot above it; the top slot empties.
  genvar g;
  generate
    for (g = 0; g < MAX_OUT; g++) begin : g_shift
      if (g < MAX_OUT-1) begin : g_mid
        assign w_shift[g] = r_tab[g+1];
      end else begin : g_top
        assign w_shift[g] = '0;
      end
    end
  endgenerate

  // Oldest-match priority encoder: scan downward so the lowest live index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = MAX_OUT-1; i >= 0; i--) begin
      if ((i < int'(r_count)) && (r_tab[i].id == ID_MAX_W'(i_pop_id))) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_at_end    = (r_tab[w_idx].cnt == r_tab[w_idx].len);
  assign o_retire    = i_pop && w_hit && (i_pop_last || w_at_end);
  assign w_inc       = i_pop && w_hit && !o_retire;
  assign o_unknown   = i_pop && !w_hit;
  assign o_early     = i_pop && w_hit && i_pop_last && !w_at_end;
  assign o_missing   = i_pop && w_hit && !i_pop_last && w_at_end;

  // Retire shrinks the queue first, so a full table with a same-cycle retire
  // still has room for the append.
  assign w_count_ret = r_count - CNT_W'(o_retire);
  assign w_accept    = i_push && (w_count_ret < CNT_W'(MAX_OUT));
  assign o_overflow  = i_push && !w_accept;
  assign w_tail      = w_count_ret[IDX_W-1:0];
  assign w_count_nxt = w_count_ret + CNT_W'(w_accept);
  assign o_count     = r_count;

  // Next table image: compact above the retired slot, bump beat count, append at tail.
  always_comb begin
    for (int i = 0; i < MAX_OUT; i++) begin
      w_nxt[i] = r_tab[i];
      if (o_retire && (i >= int'(w_idx))) w_nxt[i] = w_shift[i];
    end
    if (w_inc) w_nxt[w_idx].cnt = r_tab[w_idx].cnt + 8'd1;
    if (w_accept) begin
      w_nxt[w_tail].id  = ID_MAX_W'(i_push_id);
      w_nxt[w_tail].len = i_push_len;
      w_nxt[w_tail].cnt = 8'd0;
    end
  end

  // Table and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < MAX_OUT; i++) r_tab[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < MAX_OUT; i++) r_tab[i] <= w_nxt[i];
    end
  end

endmodule

// File: rtl/axi_rd_monitor.sv
// axi_rd_monitor: passive AXI4 read-channel monitor and protocol checker.
// Optional watchdog enabled by defining AXI_RD_MON_TIMEOUT_EN (adds err_timeout).
module axi_rd_monitor #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MAX_OUT     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_err,
  input  logic [ID_W-1:0]              ARID,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [7:0]                   ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic [3:0]                   ARREGION,
  input  logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [ID_W-1:0]              RID,
  input  logic [DATA_W-1:0]            RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  input  logic                         RREADY,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [31:0]                  txn_done_cnt,
  output logic [6:0]                   err_flags,
`ifdef AXI_RD_MON_TIMEOUT_EN
  output logic                         err_timeout,
`endif
  output logic                         err_any
);
  import axi_rd_mon_pkg::*;

  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_retire;
  logic              w_unknown;
  logic              w_early;
  logic              w_missing;
  logic              w_overflow;
  logic              w_ar_chg;
  logic              w_ar_bad;
  logic [ERR_W-1:0]  w_err_set;
  logic [ERR_W-1:0]  w_err_nxt;
  logic              w_to_nxt;
  logic [ERR_W-1:0]  r_err;
  logic              r_err_any;
  logic [31:0]       r_done;
  logic              r_cap_vld;
  logic [ID_W-1:0]   r_cap_id;
  logic [ADDR_W-1:0] r_cap_addr;
  logic [7:0]        r_cap_len;
  logic [2:0]        r_cap_size;
  logic [1:0]        r_cap_burst;
  logic [3:0]        r_cap_region;
  logic              w_unused;

  // Read data and the low RRESP bit carry nothing the checker needs.
  assign w_unused = ^{RDATA, RRESP[0]};

  assign w_ar_hs = ARVALID && ARREADY;
  assign w_r_hs  = RVALID && RREADY;

  axi_rd_mon_table #(
    .ID_W    (ID_W),
    .MAX_OUT (MAX_OUT)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_ar_hs),
    .i_push_id  (ARID),
    .i_push_len (ARLEN),
    .i_pop      (w_r_hs),
    .i_pop_id   (RID),
    .i_pop_last (RLAST),
    .o_count    (outstanding),
    .o_retire   (w_retire),
    .o_unknown  (w_unknown),
    .o_early    (w_early),
    .o_missing  (w_missing),
    .o_overflow (w_overflow)
  );

  // Hold the AR payload while the slave stalls so the next cycle can be compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld    <= 1'b0;
      r_cap_id     <= '0;
      r_cap_addr   <= '0;
      r_cap_len    <= '0;
      r_cap_size   <= '0;
      r_cap_burst  <= '0;
      r_cap_region <= '0;
    end else begin
      r_cap_vld <= ARVALID && !ARREADY;
      if (ARVALID && !ARREADY) begin
        r_cap_id     <= ARID;
        r_cap_addr   <= ARADDR;
        r_cap_len    <= ARLEN;
        r_cap_size   <= ARSIZE;
        r_cap_burst  <= ARBURST;
        r_cap_region <= ARREGION;
      end
    end
  end

  assign w_ar_chg = r_cap_vld && (!ARVALID || (ARID != r_cap_id) ||
                    (ARADDR != r_cap_addr) || (ARLEN != r_cap_len) ||
                    (ARSIZE != r_cap_size) || (ARBURST != r_cap_burst) ||
                    (ARREGION != r_cap_region));

  assign w_ar_bad = w_ar_hs && ((ARBURST == 2'b11) ||
                    ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN)));

  // Collect this cycle's violations; a new error beats a same-cycle clear.
  always_comb begin
    w_err_set                  = '0;
    w_err_set[ERR_OVERFLOW]    = w_overflow;
    w_err_set[ERR_RID_UNKNOWN] = w_unknown;
    w_err_set[ERR_RLAST_EARLY] = w_early;
    w_err_set[ERR_RLAST_MISS]  = w_missing;
    w_err_set[ERR_RRESP]       = w_r_hs && RRESP[1];
    w_err_set[ERR_AR_UNSTABLE] = w_ar_chg;
    w_err_set[ERR_AR_ILLEGAL]  = w_ar_bad;
    w_err_nxt = (clr_err ? '0 : r_err) | w_err_set;
  end

`ifdef AXI_RD_MON_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic [31:0] w_wdog_nxt;
  logic        r_err_to;

  // Watchdog idles at zero with nothing outstanding and restarts on every R beat.
  always_comb begin
    w_wdog_nxt = r_wdog;
    if (w_r_hs || (outstanding == '0)) w_wdog_nxt = '0;
    else if (r_wdog != 32'(TIMEOUT_CYC)) w_wdog_nxt = r_wdog + 32'd1;
  end

  assign w_to_nxt = (clr_err ? 1'b0 : r_err_to) | (w_wdog_nxt == 32'(TIMEOUT_CYC));

  // Watchdog counter and its sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog   <= '0;
      r_err_to <= 1'b0;
    end else begin
      r_wdog   <= w_wdog_nxt;
      r_err_to <= w_to_nxt;
    end
  end

  assign err_timeout = r_err_to;
`else
  assign w_to_nxt = 1'b0;
`endif

  // Sticky flags, their registered OR, and the saturating completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= '0;
      r_err_any <= 1'b0;
      r_done    <= '0;
    end else begin
      r_err     <= w_err_nxt;
      r_err_any <= (|w_err_nxt) | w_to_nxt;
      if (w_retire && (r_done != 32'hFFFF_FFFF)) r_done <= r_done + 32'd1;
    end
  end

  assign err_flags    = r_err;
  assign err_any      = r_err_any;
  assign txn_done_cnt = r_done;

endmodule

// File: tb/tb_axi_rd_monitor.sv
// tb_axi_rd_monitor: scenario tasks push expected output snapshots and compare
// them against DUT outputs sampled on the falling edge.
module tb_axi_rd_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARREGION;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  outstanding;
  logic [31:0] txn_done_cnt;
  logic [6:0]  err_flags;
  logic        err_any;
`ifdef AXI_RD_MON_TIMEOUT_EN
  logic        err_timeout;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [3:0]  outs;
    logic [31:0] done;
    logic [6:0]  err;
    logic        any;
  } snap_t;

  snap_t sb_exp[$];
  snap_t sb_obs[$];

  always #5 clk = ~clk;

  axi_rd_monitor #(
    .ID_W(4), .ADDR_W(32), .DATA_W(64), .MAX_OUT(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .clr_err(clr_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .outstanding(outstanding), .txn_done_cnt(txn_done_cnt), .err_flags(err_flags),
`ifdef AXI_RD_MON_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .err_any(err_any)
  );

  // Push expected outputs and capture the observed ones at the same moment.
  task automatic snap(input string nm, input int outs, input int done, input logic [6:0] err);
    snap_t e, o;
    e.nm = nm; e.outs = 4'(outs); e.done = 32'(done); e.err = err; e.any = |err;
    o.nm = nm; o.outs = outstanding; o.done = txn_done_cnt; o.err = err_flags; o.any = err_any;
    sb_exp.push_back(e);
    sb_obs.push_back(o);
  endtask

  task automatic ar_set(input int id, input int len, input logic [1:0] burst);
    ARID = 4'(id); ARLEN = 8'(len); ARBURST = burst;
    ARADDR = 32'h1000 + 32'(id) * 32'h40;
    ARVALID = 1'b1; ARREADY = 1'b1;
  endtask

  task automatic r_set(input int id, input logic last, input logic [1:0] resp);
    RID = 4'(id); RLAST = last; RRESP = resp;
    RDATA = {$urandom, $urandom};
    RVALID = 1'b1; RREADY = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    ARVALID = 1'b0; ARREADY = 1'b0;
    RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    clr_err = 1'b0;
  endtask

  task automatic ar(input int id, input int len);
    ar_set(id, len, 2'b01);
    step();
  endtask

  task automatic rb(input int id, input logic last);
    r_set(id, last, 2'b00);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t e, o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    snap("reset", 0, 0, 7'h00);
    rst = 1'b0;
    @(negedge clk);
    snap("reset_idle", 0, 0, 7'h00);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_interleave();
    snap_t e, o;
    do_reset();
    ar(1, 3);
    ar(2, 0);
    snap("il_two_out", 2, 0, 7'h00);
    rb(2, 1'b1);
    snap("il_id2_done", 1, 1, 7'h00);
    for (int i = 0; i < 3; i++) rb(1, 1'b0);
    rb(1, 1'b1);
    snap("il_all_done", 0, 2, 7'h00);
    // Same ID twice: the older (len=1) burst must take the first beats.
    ar(7, 1);
    ar(7, 0);
    rb(7, 1'b0);
    rb(7, 1'b1);
    snap("order_first", 1, 3, 7'h00);
    rb(7, 1'b1);
    snap("order_second", 0, 4, 7'h00);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_overflow();
    snap_t e, o;
    do_reset();
    for (int i = 0; i < 8; i++) ar(i, 0);
    snap("ovf_full", 8, 0, 7'h00);
    ar(8, 0);
    snap("ovf_drop", 8, 0, 7'h01);
    do_reset();
    for (int i = 0; i < 8; i++) ar(i, 0);
    ar_set(9, 0, 2'b01);
    r_set(0, 1'b1, 2'b00);
    step();
    snap("ovf_retire_same", 8, 1, 7'h00);
    for (int i = 1; i < 8; i++) rb(i, 1'b1);
    rb(9, 1'b1);
    snap("ovf_drain", 0, 9, 7'h00);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_last();
    snap_t e, o;
    do_reset();
    ar(3, 3);
    rb(3, 1'b0);
    rb(3, 1'b1);
    snap("rlast_early", 0, 1, 7'h04);
    ar(4, 1);
    rb(4, 1'b0);
    rb(4, 1'b0);
    snap("rlast_missing", 0, 2, 7'h0C);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_unknown_clr();
    snap_t e, o;
    do_reset();
    rb(5, 1'b1);
    snap("rid_unknown", 0, 0, 7'h02);
    clr_err = 1'b1;
    step();
    snap("clr_err", 0, 0, 7'h00);
    clr_err = 1'b1;
    r_set(6, 1'b1, 2'b00);
    step();
    snap("clr_vs_new_err", 0, 0, 7'h02);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_ar_checks();
    snap_t e, o;
    do_reset();
    ARID = 4'd2; ARLEN = 8'd0; ARBURST = 2'b01; ARADDR = 32'h100;
    ARVALID = 1'b1; ARREADY = 1'b0;
    @(negedge clk);
    ARADDR = 32'h104;
    @(negedge clk);
    ARVALID = 1'b0;
    @(negedge clk);
    snap("ar_unstable", 0, 0, 7'h20);
    ar_set(2, 3, 2'b10);
    step();
    snap("wrap_len3_ok", 1, 0, 7'h20);
    rb(2, 1'b0); rb(2, 1'b0); rb(2, 1'b0); rb(2, 1'b1);
    ar_set(2, 2, 2'b10);
    step();
    snap("wrap_len2_bad", 1, 1, 7'h60);
    r_set(2, 1'b0, 2'b10);
    step();
    snap("rresp_slverr", 1, 1, 7'h70);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    do_reset();
    ar(1, 3);
    rb(1, 1'b0);
    snap("mid_before_rst", 1, 0, 7'h00);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    snap("mid_async_rst", 0, 0, 7'h00);
    @(negedge clk);
    rb(1, 1'b1);
    snap("mid_stale_beat", 0, 0, 7'h02);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); checks++;
      if (o.outs !== e.outs || o.done !== e.done || o.err !== e.err || o.any !== e.any) begin
        errors++;
        $display("FAIL %s: got out=%0d done=%0d err=%b any=%b want out=%0d done=%0d err=%b any=%b",
                 e.nm, o.outs, o.done, o.err, o.any, e.outs, e.done, e.err, e.any);
      end
    end
  endtask

`ifdef AXI_RD_MON_TIMEOUT_EN
  task automatic test_timeout();
    logic exp_to;
    do_reset();
    ar(1, 0);
    repeat (5) @(negedge clk);
    exp_to = 1'b0; checks++;
    if (err_timeout !== exp_to) begin
      errors++;
      $display("FAIL timeout_early: got %b want %b", err_timeout, exp_to);
    end
    repeat (15) @(negedge clk);
    exp_to = 1'b1; checks++;
    if (err_timeout !== exp_to || err_any !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got to=%b any=%b want to=%b any=1", err_timeout, err_any, exp_to);
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    exp_to = 1'b0; checks++;
    if (err_timeout !== exp_to || err_any !== 1'b0 || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL timeout_rst: got to=%b any=%b out=%0d want all 0", err_timeout, err_any, outstanding);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd3; ARBURST = 2'b01; ARREGION = '0;
    ARVALID = 1'b0; ARREADY = 1'b0;
    RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_interleave();
    test_overflow();
    test_last();
    test_unknown_clr();
    test_ar_checks();
    test_reset_mid();
`ifdef AXI_RD_MON_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
